// File: rtl/seg_scan_driver_if.sv
// Bus bundle for seg_scan_driver: shadow-load input and the registered display outputs.
interface seg_scan_driver_if;
  logic        load;
  logic [31:0] din;
  logic [7:0]  an;
  logic [7:0]  seg;
  logic        frame;

  modport master (output load, din, input an, seg, frame);
  modport slave  (input load, din, output an, seg, frame);
endinterface

// File: rtl/seg_scan_driver.sv
// Multiplexed 8-digit active-low 7-segment scanner fed from a 32-bit shadow register.
// Optional build macro SEG_LEADING_ZERO_BLANK_EN blanks leading-zero digits.
module seg_scan_driver #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic               clk,
  input  logic               rst_n,
  seg_scan_driver_if.slave   bus
);

  localparam logic [15:0] CNT_MAX = 16'(SCAN_DIV - 1);

  logic [31:0] shadow;
  logic [15:0] cnt;
  logic [2:0]  digit;
  logic        wrapPending;
  logic [7:0]  anReg;
  logic [7:0]  segReg;
  logic        frameReg;

  logic        advance;
  logic [4:0]  bitBase;
  logic [3:0]  nibble;
  logic        blank;
  logic [7:0]  anNext;
  logic [7:0]  segNext;

  function automatic logic [7:0] decodeHex(input logic [3:0] n);
    case (n)
      4'h0: decodeHex = 8'hC0;
      4'h1: decodeHex = 8'hF9;
      4'h2: decodeHex = 8'hA4;
      4'h3: decodeHex = 8'hB0;
      4'h4: decodeHex = 8'h99;
      4'h5: decodeHex = 8'h92;
      4'h6: decodeHex = 8'h82;
      4'h7: decodeHex = 8'hF8;
      4'h8: decodeHex = 8'h80;
      4'h9: decodeHex = 8'h90;
      4'hA: decodeHex = 8'h88;
      4'hB: decodeHex = 8'h83;
      4'hC: decodeHex = 8'hC6;
      4'hD: decodeHex = 8'hA1;
      4'hE: decodeHex = 8'h86;
      default: decodeHex = 8'h8E;
    endcase
  endfunction

  assign advance = (cnt == CNT_MAX);
  assign bitBase = {digit, 2'b00};
  assign nibble  = shadow[bitBase +: 4];

`ifdef SEG_LEADING_ZERO_BLANK_EN
  // Digit 0 always shows, so a zero value still reads as a single "0".
  always_comb begin
    blank = 1'b0;
    if (digit != 3'd0)
      blank = ((shadow >> bitBase) == 32'h0);
  end
`else
  assign blank = 1'b0;
`endif

  assign anNext  = ~(8'b1 << digit);
  assign segNext = blank ? 8'hFF : decodeHex(nibble);

  // wrapPending delays the 7->0 step by one edge so frame lines up with an going FE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow      <= 32'h0;
      cnt         <= 16'd0;
      digit       <= 3'd0;
      wrapPending <= 1'b0;
      anReg       <= 8'hFF;
      segReg      <= 8'hFF;
      frameReg    <= 1'b0;
    end else begin
      if (bus.load)
        shadow <= bus.din;
      if (advance) begin
        cnt   <= 16'd0;
        digit <= digit + 3'd1;
      end else begin
        cnt <= cnt + 16'd1;
      end
      wrapPending <= advance && (digit == 3'd7);
      anReg       <= anNext;
      segReg      <= segNext;
      frameReg    <= wrapPending;
    end
  end

  assign bus.an    = anReg;
  assign bus.seg   = segReg;
  assign bus.frame = frameReg;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed, table-driven bench for seg_scan_driver with SCAN_DIV=4 and SCAN_DIV=1 instances.
module tb_seg_scan_driver;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   edgeNum;

  seg_scan_driver_if bus4 ();
  seg_scan_driver_if bus1 ();

  seg_scan_driver #(.SCAN_DIV(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
  seg_scan_driver #(.SCAN_DIV(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] din;
    int          digit;
    logic [7:0]  expAn;
    logic [7:0]  expSeg;
  } vec_t;

  vec_t vecs[13];

`ifdef SEG_LEADING_ZERO_BLANK_EN
  localparam logic [7:0] LEAD_ZERO = 8'hFF;
`else
  localparam logic [7:0] LEAD_ZERO = 8'hC0;
`endif

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s at edge %0d: got %02h expected %02h", name, edgeNum, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic ld, input logic [31:0] d);
    bus4.load = ld;
    bus4.din  = d;
    bus1.load = ld;
    bus1.din  = d;
  endtask

  task automatic stepEdge();
    @(posedge clk);
    #1;
    edgeNum++;
  endtask

  task automatic stepTo(input int n);
    while (edgeNum < n) stepEdge();
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    applyStimulus(1'b0, 32'h0);
    #1;
    checkOutput("rst_an", bus4.an, 8'hFF);
    checkOutput("rst_seg", bus4.seg, 8'hFF);
    checkOutput("rst_frame", {7'd0, bus4.frame}, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    edgeNum = 0;
  endtask

  initial begin
    logic [7:0] expAn;
    logic       expFrame;
    checks   = 0;
    failures = 0;
    edgeNum  = 0;
    rst_n    = 1'b0;
    applyStimulus(1'b0, 32'h0);

    vecs[0]  = '{32'h89ABCDEF, 0, 8'hFE, 8'h8E};
    vecs[1]  = '{32'h89ABCDEF, 1, 8'hFD, 8'h86};
    vecs[2]  = '{32'h89ABCDEF, 2, 8'hFB, 8'hA1};
    vecs[3]  = '{32'h89ABCDEF, 3, 8'hF7, 8'hC6};
    vecs[4]  = '{32'h89ABCDEF, 4, 8'hEF, 8'h83};
    vecs[5]  = '{32'h89ABCDEF, 5, 8'hDF, 8'h88};
    vecs[6]  = '{32'h89ABCDEF, 6, 8'hBF, 8'h90};
    vecs[7]  = '{32'h89ABCDEF, 7, 8'h7F, 8'h80};
    vecs[8]  = '{32'h00000120, 0, 8'hFE, 8'hC0};
    vecs[9]  = '{32'h00000120, 1, 8'hFD, 8'hA4};
    vecs[10] = '{32'h00000120, 2, 8'hFB, 8'hF9};
    vecs[11] = '{32'h00000120, 3, 8'hF7, LEAD_ZERO};
    vecs[12] = '{32'h00000120, 7, 8'h7F, LEAD_ZERO};

    // Free-running scan with an all-zero shadow.
    doReset();
    for (int k = 1; k <= 68; k++) begin
      stepEdge();
      expAn    = ~(8'h01 << (((k - 1) / 4) % 8));
      expFrame = (k > 1) && (((k - 1) % 32) == 0);
      checkOutput("scan_an", bus4.an, expAn);
      checkOutput("scan_seg", bus4.seg, 8'hC0);
      checkOutput("scan_frame", {7'd0, bus4.frame}, {7'd0, expFrame});
    end

    // Per-digit decode vectors: load on edge 1, digit d visible from edge 4d+2.
    for (int i = 0; i < 13; i++) begin
      doReset();
      applyStimulus(1'b1, vecs[i].din);
      stepEdge();
      applyStimulus(1'b0, 32'h0);
      stepTo(4 * vecs[i].digit + 2);
      checkOutput($sformatf("vec%0d_an", i), bus4.an, vecs[i].expAn);
      checkOutput($sformatf("vec%0d_seg", i), bus4.seg, vecs[i].expSeg);
    end

    // Load landing on the same edge as the 0->1 advance.
    doReset();
    stepTo(3);
    applyStimulus(1'b1, 32'h00000050);
    stepEdge();
    applyStimulus(1'b0, 32'h0);
    checkOutput("ldadv_an_e4", bus4.an, 8'hFE);
    checkOutput("ldadv_seg_e4", bus4.seg, 8'hC0);
    stepEdge();
    checkOutput("ldadv_an_e5", bus4.an, 8'hFD);
    checkOutput("ldadv_seg_e5", bus4.seg, 8'h92);
    stepTo(8);
    checkOutput("ldadv_an_e8", bus4.an, 8'hFD);
    stepEdge();
    checkOutput("ldadv_an_e9", bus4.an, 8'hFB);

    // Reset pulse while digit 5 is lit; load during reset must be ignored.
    doReset();
    applyStimulus(1'b1, 32'h12345678);
    stepEdge();
    applyStimulus(1'b0, 32'h0);
    stepTo(22);
    checkOutput("mid_an_pre", bus4.an, 8'hDF);
    checkOutput("mid_seg_pre", bus4.seg, 8'hB0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_an_async", bus4.an, 8'hFF);
    checkOutput("mid_seg_async", bus4.seg, 8'hFF);
    checkOutput("mid_frame_async", {7'd0, bus4.frame}, 8'h00);
    applyStimulus(1'b1, 32'hFFFFFFFF);
    @(posedge clk);
    #1;
    checkOutput("mid_an_held", bus4.an, 8'hFF);
    checkOutput("mid_seg_held", bus4.seg, 8'hFF);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0);
    rst_n   = 1'b1;
    edgeNum = 0;
    stepEdge();
    checkOutput("mid_an_rel", bus4.an, 8'hFE);
    checkOutput("mid_seg_rel", bus4.seg, 8'hC0);
    stepTo(5);
    checkOutput("mid_an_e5", bus4.an, 8'hFD);
    checkOutput("mid_seg_e5", bus4.seg, 8'hC0);

    // SCAN_DIV=1: one digit per clock, frame every 8th clock.
    doReset();
    for (int k = 1; k <= 24; k++) begin
      stepEdge();
      expAn    = ~(8'h01 << ((k - 1) % 8));
      expFrame = (k > 1) && (((k - 1) % 8) == 0);
      checkOutput("div1_an", bus1.an, expAn);
      checkOutput("div1_frame", {7'd0, bus1.frame}, {7'd0, expFrame});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, meaning clk cycles each digit stays lit (legal range 1..65535).
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on posedge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port load  input  1  capture din into shadow register when high at posedge.
REQ-005 SHALL have port din  input  32  value from output device current-data register, 8 hex nibbles, nibble 0 = din[3:0].
REQ-006 SHALL have port an  output  8  digit enables, active-low, an[i] selects digit i.
REQ-007 SHALL have port seg  output  8  segments, active-low, seg[6:0]=g..a, seg[7]=dp.
REQ-008 SHALL have port frame  output  1  one-cycle pulse when scan wraps from digit 7 to digit 0.

Function
REQ-009 SHALL hold a 32-bit shadow register; load=1 at posedge writes din, load=0 holds; display never reads din directly.
REQ-010 SHALL run a prescaler cnt counting 0..SCAN_DIV-1; at SCAN_DIV-1 cnt returns to 0 and digit index advances.
REQ-011 SHALL advance digit index 0->1->...->7->0 (3-bit wrap), exactly one step per SCAN_DIV cycles; SCAN_DIV=1 advances every cycle.
REQ-012 SHALL register an and seg: outputs reflect digit index and shadow value of the previous cycle (latency 1 clk).
REQ-013 SHALL drive an = ~(8'b1 << digit): exactly one bit low at all times after the first post-reset edge.
REQ-014 SHALL decode nibble shadow[4*digit+3 : 4*digit] to seg[6:0] active-low: 0=C0,1=F9,2=A4,3=B0,4=99,5=92,6=82,7=F8,8=80,9=90,A=88,B=83,C=C6,D=A1,E=86,F=8E (values given as full seg byte with dp=1).
REQ-015 SHALL keep seg[7] (dp) = 1 (off) always.
REQ-016 SHALL assert frame (registered) for exactly one cycle, coincident with an changing from 8'h7F to 8'hFE.
REQ-017 SHALL, on load coinciding with a digit advance, display the new shadow nibble for the new digit (load and advance both take effect on the same edge).
REQ-018 SHALL not reset cnt or digit on load; scan timing is independent of load activity.

Reset
REQ-019 SHALL, while rst_n=0, force shadow=32'h0, cnt=0, digit=0, an=8'hFF, seg=8'hFF, frame=0, independent of clk.
REQ-020 SHALL ignore load while rst_n=0; first posedge after release shows an=8'hFE, seg=8'hC0.
REQ-021 SHALL, on reset asserted mid-scan, abandon the current digit and restart from digit 0 with cnt=0 after release.

Configuration
REQ-022 SHALL, with macro SEG_LEADING_ZERO_BLANK_EN defined, blank digit i (seg=8'hFF, an unchanged) when i!=0 and nibbles i..7 of shadow are all zero.
REQ-023 SHALL, without SEG_LEADING_ZERO_BLANK_EN, display all 8 digits including leading zeros; scan timing identical in both builds.

Verification
REQ-024 SHALL cover: SCAN_DIV=4, reset release, no load -> an steps FE,FD,FB,...,7F,FE every 4 clks, seg=C0 throughout, frame pulse every 32 clks.
REQ-025 SHALL cover: load din=32'h89ABCDEF, SCAN_DIV=4 -> digits 0..7 show 8E,86,A1,C6,83,88,90,80.
REQ-026 SHALL cover: load asserted on same edge as advance 0->1 with din=32'h00000050 -> digit 1 shows 92 on its first lit cycle.
REQ-027 SHALL cover: rst_n pulsed low mid-cycle while digit 5 lit -> an=FF, seg=FF immediately; after release an=FE, seg=C0, shadow=0.
REQ-028 SHALL cover: SEG_LEADING_ZERO_BLANK_EN defined, din=32'h00000120 -> digits 3..7 seg=FF, digit 2=F9, digit 1=A4, digit 0=C0; undefined -> digits 3..7 show C0.
REQ-029 SHALL cover: SCAN_DIV=1 -> an changes every clk, frame high every 8th clk.
